// File: rtl/uvma_rvfi_pkg.sv
// ============================================================================
// uvma_rvfi_pkg : shared types, FSM states and default CSR address table
// Rev 1.0
// ============================================================================
`default_nettype none

package uvma_rvfi_pkg;

  localparam int unsigned MAX_CSR   = 64;
  localparam int unsigned CSR_IDX_W = 6;

  typedef logic [11:0] csr_addr_t;
  typedef csr_addr_t [MAX_CSR-1:0] csr_addr_tbl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_DRAIN = 2'd2
  } ser_state_e;

  function automatic csr_addr_tbl_t default_csr_addr();
    csr_addr_tbl_t tbl;
    tbl = '0;
    tbl[0]  = 12'h300;  // mstatus
    tbl[1]  = 12'h301;  // misa
    tbl[2]  = 12'h304;  // mie
    tbl[3]  = 12'h305;  // mtvec
    tbl[4]  = 12'h340;  // mscratch
    tbl[5]  = 12'h341;  // mepc
    tbl[6]  = 12'h342;  // mcause
    tbl[7]  = 12'h343;  // mtval
    tbl[8]  = 12'h34A;  // mtinst
    tbl[9]  = 12'h344;  // mip
    tbl[10] = 12'h7B0;  // dcsr
    tbl[11] = 12'h7B1;  // dpc
    tbl[12] = 12'hB00;  // mcycle
    tbl[13] = 12'hB02;  // minstret
    tbl[14] = 12'hF14;  // mhartid
    tbl[15] = 12'hF11;  // mvendorid
    // Upper slots cover mhpmcounter3..31 then mhpmevent3..21
    for (int i = 16; i < 45; i++) tbl[i] = 12'hB03 + 12'(i - 16);
    for (int i = 45; i < 64; i++) tbl[i] = 12'h323 + 12'(i - 45);
    return tbl;
  endfunction

  localparam csr_addr_tbl_t DEFAULT_CSR_ADDR = default_csr_addr();

endpackage

`default_nettype wire

// File: rtl/uvma_rvfi_csr_serializer_if.sv
// ============================================================================
// uvma_rvfi_csr_serializer_if : snapshot-in / CSR-beat-out bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface uvma_rvfi_csr_serializer_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_CSR = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CSR*XLEN-1:0] in_rmask;
  logic [NUM_CSR*XLEN-1:0] in_wmask;
  logic [NUM_CSR*XLEN-1:0] in_rdata;
  logic [NUM_CSR*XLEN-1:0] in_wdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_addr;
  logic [XLEN-1:0]         out_rmask;
  logic [XLEN-1:0]         out_wmask;
  logic [XLEN-1:0]         out_rdata;
  logic [XLEN-1:0]         out_wdata;
  logic                    out_last;
  logic [15:0]             empty_cnt;

  modport master (
    output in_valid, in_rmask, in_wmask, in_rdata, in_wdata, out_ready,
    input  in_ready, out_valid, out_addr, out_rmask, out_wmask,
           out_rdata, out_wdata, out_last, empty_cnt
  );

  modport slave (
    input  in_valid, in_rmask, in_wmask, in_rdata, in_wdata, out_ready,
    output in_ready, out_valid, out_addr, out_rmask, out_wmask,
           out_rdata, out_wdata, out_last, empty_cnt
  );

endinterface

`default_nettype wire

// File: rtl/uvma_rvfi_csr_prio_enc.sv
// ============================================================================
// uvma_rvfi_csr_prio_enc : lowest-set-bit priority encoder
// Rev 1.0
// ============================================================================
`default_nettype none

module uvma_rvfi_csr_prio_enc #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 4
) (
  input  wire [N-1:0]     vec,
  output logic [IDX_W-1:0] index,
  output logic             any,
  output logic [N-1:0]     onehot
);

  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
  end

  assign onehot = vec & (~vec + N'(1));
  assign any    = |vec;

endmodule

`default_nettype wire

// File: rtl/uvma_rvfi_csr_serializer.sv
// ============================================================================
// uvma_rvfi_csr_serializer : per-retirement CSR snapshot to single-CSR beats
// Rev 1.0
// ============================================================================
`default_nettype none

module uvma_rvfi_csr_serializer
  import uvma_rvfi_pkg::*;
#(
  parameter int unsigned   XLEN     = 32,
  parameter int unsigned   NUM_CSR  = 16,
  parameter csr_addr_tbl_t CSR_ADDR = DEFAULT_CSR_ADDR
) (
  input wire                        clk,
  input wire                        reset_n,
  uvma_rvfi_csr_serializer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_CSR);

  ser_state_e         state_q, state_d;
  logic [NUM_CSR-1:0] pending_q, pending_d;
  logic [XLEN-1:0]    snap_rmask_q [NUM_CSR];
  logic [XLEN-1:0]    snap_wmask_q [NUM_CSR];
  logic [XLEN-1:0]    snap_rdata_q [NUM_CSR];
  logic [XLEN-1:0]    snap_wdata_q [NUM_CSR];
  logic [XLEN-1:0]    snap_rmask_d [NUM_CSR];
  logic [XLEN-1:0]    snap_wmask_d [NUM_CSR];
  logic [XLEN-1:0]    snap_rdata_d [NUM_CSR];
  logic [XLEN-1:0]    snap_wdata_d [NUM_CSR];
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [XLEN-1:0]    out_addr_q, out_addr_d;
  logic [XLEN-1:0]    out_rmask_q, out_rmask_d;
  logic [XLEN-1:0]    out_wmask_q, out_wmask_d;
  logic [XLEN-1:0]    out_rdata_q, out_rdata_d;
  logic [XLEN-1:0]    out_wdata_q, out_wdata_d;
  logic [15:0]        empty_cnt_q, empty_cnt_d;

  logic [XLEN-1:0]    in_rmask_a [NUM_CSR];
  logic [XLEN-1:0]    in_wmask_a [NUM_CSR];
  logic [XLEN-1:0]    in_rdata_a [NUM_CSR];
  logic [XLEN-1:0]    in_wdata_a [NUM_CSR];
  logic [NUM_CSR-1:0] active_vec;
  logic [NUM_CSR-1:0] enc_in;
  logic [NUM_CSR-1:0] enc_onehot;
  logic [NUM_CSR-1:0] remaining;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic               load;

  for (genvar gi = 0; gi < NUM_CSR; gi++) begin : g_slot
    assign in_rmask_a[gi] = bus.in_rmask[gi*XLEN +: XLEN];
    assign in_wmask_a[gi] = bus.in_wmask[gi*XLEN +: XLEN];
    assign in_rdata_a[gi] = bus.in_rdata[gi*XLEN +: XLEN];
    assign in_wdata_a[gi] = bus.in_wdata[gi*XLEN +: XLEN];
    assign active_vec[gi] = |(in_rmask_a[gi] | in_wmask_a[gi]);
  end

  // pending_q holds slots not yet presented; the presented slot is already cleared
  assign enc_in    = (state_q == ST_IDLE) ? active_vec : pending_q;
  assign remaining = enc_in & ~enc_onehot;

  uvma_rvfi_csr_prio_enc #(
    .N     (NUM_CSR),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec    (enc_in),
    .index  (enc_idx),
    .any    (enc_any),
    .onehot (enc_onehot)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    snap_rmask_d = snap_rmask_q;
    snap_wmask_d = snap_wmask_q;
    snap_rdata_d = snap_rdata_q;
    snap_wdata_d = snap_wdata_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_addr_d   = out_addr_q;
    out_rmask_d  = out_rmask_q;
    out_wmask_d  = out_wmask_q;
    out_rdata_d  = out_rdata_q;
    out_wdata_d  = out_wdata_q;
    empty_cnt_d  = empty_cnt_q;
    load         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          snap_rmask_d = in_rmask_a;
          snap_wmask_d = in_wmask_a;
          snap_rdata_d = in_rdata_a;
          snap_wdata_d = in_wdata_a;
          if (enc_any) begin
            load    = 1'b1;
            state_d = ST_EMIT;
          end else if (empty_cnt_q != 16'hFFFF) begin
            empty_cnt_d = empty_cnt_q + 16'd1;
          end
        end
      end
      ST_EMIT: begin
        if (out_valid_q && bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_DRAIN;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // In IDLE the snapshot is still being captured, so read the live inputs
    if (load) begin
      pending_d   = remaining;
      out_valid_d = 1'b1;
      out_last_d  = ~|remaining;
      out_addr_d  = {{(XLEN-12){1'b0}}, CSR_ADDR[CSR_IDX_W'(enc_idx)]};
      out_rmask_d = (state_q == ST_IDLE) ? in_rmask_a[enc_idx] : snap_rmask_q[enc_idx];
      out_wmask_d = (state_q == ST_IDLE) ? in_wmask_a[enc_idx] : snap_wmask_q[enc_idx];
      out_rdata_d = (state_q == ST_IDLE) ? in_rdata_a[enc_idx] : snap_rdata_q[enc_idx];
      out_wdata_d = (state_q == ST_IDLE) ? in_wdata_a[enc_idx] : snap_wdata_q[enc_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      snap_rmask_q <= '{default: '0};
      snap_wmask_q <= '{default: '0};
      snap_rdata_q <= '{default: '0};
      snap_wdata_q <= '{default: '0};
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_addr_q   <= '0;
      out_rmask_q  <= '0;
      out_wmask_q  <= '0;
      out_rdata_q  <= '0;
      out_wdata_q  <= '0;
      empty_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      snap_rmask_q <= snap_rmask_d;
      snap_wmask_q <= snap_wmask_d;
      snap_rdata_q <= snap_rdata_d;
      snap_wdata_q <= snap_wdata_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_addr_q   <= out_addr_d;
      out_rmask_q  <= out_rmask_d;
      out_wmask_q  <= out_wmask_d;
      out_rdata_q  <= out_rdata_d;
      out_wdata_q  <= out_wdata_d;
      empty_cnt_q  <= empty_cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_rmask = out_rmask_q;
  assign bus.out_wmask = out_wmask_q;
  assign bus.out_rdata = out_rdata_q;
  assign bus.out_wdata = out_wdata_q;
  assign bus.empty_cnt = empty_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uvma_rvfi_csr_serializer.sv
// ============================================================================
// tb_uvma_rvfi_csr_serializer : directed self-checking bench for the serializer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uvma_rvfi_csr_serializer;

  localparam int XLEN    = 32;
  localparam int NUM_CSR = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  logic [11:0] exp_addr [16] = '{12'h300, 12'h301, 12'h304, 12'h305,
                                 12'h340, 12'h341, 12'h342, 12'h343,
                                 12'h34A, 12'h344, 12'h7B0, 12'h7B1,
                                 12'hB00, 12'hB02, 12'hF14, 12'hF11};

  uvma_rvfi_csr_serializer_if #(.XLEN(XLEN), .NUM_CSR(NUM_CSR)) bus ();

  uvma_rvfi_csr_serializer #(.XLEN(XLEN), .NUM_CSR(NUM_CSR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid = 1'b0;
    bus.in_rmask = '0;
    bus.in_wmask = '0;
    bus.in_rdata = '0;
    bus.in_wdata = '0;
  endtask

  task automatic set_slot(input int i, input logic [31:0] rm, input logic [31:0] wm,
                          input logic [31:0] rd, input logic [31:0] wd);
    bus.in_rmask[i*XLEN +: XLEN] = rm;
    bus.in_wmask[i*XLEN +: XLEN] = wm;
    bus.in_rdata[i*XLEN +: XLEN] = rd;
    bus.in_wdata[i*XLEN +: XLEN] = wd;
  endtask

  task automatic send();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_last} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 100", {bus.in_ready, bus.out_valid, bus.out_last});
    end
    n_cmp++;
    if ({bus.out_addr, bus.out_rmask, bus.out_wmask, bus.out_rdata, bus.out_wdata, bus.empty_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%h rm=%h wm=%h rd=%h wd=%h cnt=%h expected all zero",
               bus.out_addr, bus.out_rmask, bus.out_wmask, bus.out_rdata, bus.out_wdata, bus.empty_cnt);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_three_slots();
    int          slots [3]  = '{2, 5, 9};
    logic [31:0] addrs [3]  = '{32'h304, 32'h341, 32'h344};
    logic [31:0] rmv   [3]  = '{32'hFFFF_FFFF, 32'h0, 32'h1};
    logic [31:0] wmv   [3]  = '{32'h0, 32'hF, 32'h1};
    logic [31:0] rdv   [3]  = '{32'h11, 32'h0, 32'h33};
    logic [31:0] wdv   [3]  = '{32'h0, 32'h22, 32'h44};
    clear_in();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) set_slot(slots[k], rmv[k], wmv[k], rdv[k], wdv[k]);
    send();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out_last, bus.out_addr} !== {1'b0, 1'b1, (k == 2), addrs[k]}) begin
        n_bad++;
        $display("FAIL three_ctrl beat %0d: got rdy=%b v=%b last=%b addr=%h expected rdy=0 v=1 last=%b addr=%h",
                 k, bus.in_ready, bus.out_valid, bus.out_last, bus.out_addr, (k == 2), addrs[k]);
      end
      n_cmp++;
      if ({bus.out_rmask, bus.out_wmask, bus.out_rdata, bus.out_wdata} !== {rmv[k], wmv[k], rdv[k], wdv[k]}) begin
        n_bad++;
        $display("FAIL three_data beat %0d: got %h %h %h %h expected %h %h %h %h", k,
                 bus.out_rmask, bus.out_wmask, bus.out_rdata, bus.out_wdata, rmv[k], wmv[k], rdv[k], wdv[k]);
      end
      tick();
    end
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_last} !== 3'b000) begin
      n_bad++;
      $display("FAIL three_drain: got %b expected 000", {bus.in_ready, bus.out_valid, bus.out_last});
    end
    tick();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL three_idle: got %b expected 10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_backpressure();
    clear_in();
    bus.out_ready = 1'b0;
    set_slot(0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1888);
    send();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({bus.out_valid, bus.out_last, bus.out_addr, bus.out_wmask, bus.out_wdata, bus.out_rmask}
          !== {1'b1, 1'b1, 32'h300, 32'hFFFF_FFFF, 32'h1888, 32'h0}) begin
        n_bad++;
        $display("FAIL stall cycle %0d: got v=%b last=%b addr=%h wm=%h wd=%h rm=%h expected 1 1 300 ffffffff 1888 0",
                 c, bus.out_valid, bus.out_last, bus.out_addr, bus.out_wmask, bus.out_wdata, bus.out_rmask);
      end
      if (c < 4) tick();
    end
    bus.out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL stall_release: got v/rdy=%b expected 00", {bus.out_valid, bus.in_ready});
    end
    tick();
  endtask

  task automatic test_empty();
    clear_in();
    bus.in_rdata = {NUM_CSR{32'hCAFE_F00D}};
    for (int r = 0; r < 3; r++) begin
      send();
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
        n_bad++;
        $display("FAIL empty_ctrl %0d: got v/rdy=%b expected 01", r, {bus.out_valid, bus.in_ready});
      end
    end
    n_cmp++;
    if (bus.empty_cnt !== 16'd3) begin
      n_bad++;
      $display("FAIL empty_cnt: got %0d expected 3", bus.empty_cnt);
    end
  endtask

  task automatic test_all_slots();
    clear_in();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) set_slot(i, 32'(i + 1), 32'h0, 32'hA000 + 32'(i), 32'hB000 + 32'(i));
    send();
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({bus.out_valid, bus.out_last, bus.out_addr} !== {1'b1, (k == 15), {20'h0, exp_addr[k]}}) begin
        n_bad++;
        $display("FAIL all_ctrl beat %0d: got v=%b last=%b addr=%h expected v=1 last=%b addr=%h",
                 k, bus.out_valid, bus.out_last, bus.out_addr, (k == 15), exp_addr[k]);
      end
      n_cmp++;
      if ({bus.out_rmask, bus.out_wmask, bus.out_rdata, bus.out_wdata}
          !== {32'(k + 1), 32'h0, 32'hA000 + 32'(k), 32'hB000 + 32'(k)}) begin
        n_bad++;
        $display("FAIL all_data beat %0d: got %h %h %h %h expected %h 0 %h %h", k,
                 bus.out_rmask, bus.out_wmask, bus.out_rdata, bus.out_wdata,
                 32'(k + 1), 32'hA000 + 32'(k), 32'hB000 + 32'(k));
      end
      for (int j = 0; j < 16; j++) set_slot(j, $urandom, $urandom, $urandom, $urandom);
      tick();
    end
    n_cmp++;
    if ({bus.out_valid, bus.out_last, bus.in_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL all_drain: got %b expected 000", {bus.out_valid, bus.out_last, bus.in_ready});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_in();
    bus.out_ready = 1'b1;
    set_slot(1, 32'h1, 32'h0, 32'h10, 32'h0);
    set_slot(3, 32'h1, 32'h0, 32'h30, 32'h0);
    set_slot(6, 32'h1, 32'h0, 32'h60, 32'h0);
    set_slot(8, 32'h1, 32'h0, 32'h80, 32'h0);
    send();
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_addr} !== {1'b1, 32'h305}) begin
      n_bad++;
      $display("FAIL mid_beat2: got v=%b addr=%h expected v=1 addr=305", bus.out_valid, bus.out_addr);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_last, bus.in_ready, bus.empty_cnt, bus.out_addr} !== {3'b001, 16'd0, 32'h0}) begin
      n_bad++;
      $display("FAIL mid_async: got v=%b last=%b rdy=%b cnt=%0d addr=%h expected 0 0 1 0 0",
               bus.out_valid, bus.out_last, bus.in_ready, bus.empty_cnt, bus.out_addr);
    end
    #1 reset_n = 1'b1;
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_after: got v/rdy=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    clear_in();
    set_slot(7, 32'h0, 32'h3, 32'h0, 32'h77);
    set_slot(12, 32'h0, 32'h5, 32'h0, 32'hCC);
    send();
    n_cmp++;
    if ({bus.out_valid, bus.out_last, bus.out_addr, bus.out_wdata} !== {2'b10, 32'h343, 32'h77}) begin
      n_bad++;
      $display("FAIL mid_new0: got v=%b last=%b addr=%h wd=%h expected 1 0 343 77",
               bus.out_valid, bus.out_last, bus.out_addr, bus.out_wdata);
    end
    tick();
    n_cmp++;
    if ({bus.out_valid, bus.out_last, bus.out_addr, bus.out_wdata} !== {2'b11, 32'hB00, 32'hCC}) begin
      n_bad++;
      $display("FAIL mid_new1: got v=%b last=%b addr=%h wd=%h expected 1 1 b00 cc",
               bus.out_valid, bus.out_last, bus.out_addr, bus.out_wdata);
    end
    tick();
    tick();
  endtask

  task automatic test_rmask_only();
    clear_in();
    bus.out_ready = 1'b1;
    set_slot(4, 32'hFFFF_FFFF, 32'h0, 32'hDEAD, 32'h0);
    send();
    n_cmp++;
    if ({bus.out_valid, bus.out_last, bus.out_addr, bus.out_rmask, bus.out_wmask, bus.out_rdata}
        !== {2'b11, 32'h340, 32'hFFFF_FFFF, 32'h0, 32'hDEAD}) begin
      n_bad++;
      $display("FAIL rmask_only: got v=%b last=%b addr=%h rm=%h wm=%h rd=%h expected 1 1 340 ffffffff 0 dead",
               bus.out_valid, bus.out_last, bus.out_addr, bus.out_rmask, bus.out_wmask, bus.out_rdata);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rmask_only_end: got v=%b expected 0", bus.out_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_three_slots();
    test_backpressure();
    test_empty();
    test_all_slots();
    test_reset_mid();
    test_rmask_only();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
